// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer: filter-load sequencer for the PE array write port.
// Takes a load command (filter count, kernel count, first group) and consumes a
// weight stream over valid/ready. For each beat it drives a one-hot PE write
// enable that walks lane by lane through each filter group and skips unused lanes.
// Optional feature macro: PE_LOAD_BCAST_EN adds a 'bcast' input. With bcast set,
// each beat writes one lane in every selected group at the same time.
module pe_load_sequencer #(
  parameter int unsigned MAX_FILTERNUM   = 64,
  parameter int unsigned MAX_KERNELNUM   = 8,
  parameter int unsigned FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
  parameter int unsigned KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef PE_LOAD_BCAST_EN
  input  logic                       bcast,
`endif
  input  logic                       start,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  input  logic [FILTERNUM_WIDTH-1:0] first_filter,
  input  logic                       w_valid,
  output logic                       w_ready,
  output logic [MAX_FILTERNUM-1:0]   pe_en,
  output logic [FILTERNUM_WIDTH-1:0] cur_filter,
  output logic [KERNELNUM_WIDTH-1:0] cur_kernel,
  output logic                       last,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int unsigned NUM_GROUPS = MAX_FILTERNUM / MAX_KERNELNUM;
  localparam int unsigned FwExt      = FILTERNUM_WIDTH + 1;
  localparam logic [FILTERNUM_WIDTH:0]   GroupsExt = FwExt'(NUM_GROUPS);
  localparam logic [KERNELNUM_WIDTH-1:0] MaxKernel = KERNELNUM_WIDTH'(MAX_KERNELNUM);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                     state_q, state_d;
  logic [FILTERNUM_WIDTH-1:0] nf_q, nf_d;
  logic [KERNELNUM_WIDTH-1:0] nk_q, nk_d;
  logic [FILTERNUM_WIDTH-1:0] ff_q, ff_d;
  logic [FILTERNUM_WIDTH-1:0] grp_q, grp_d;
  logic [KERNELNUM_WIDTH-1:0] lane_q, lane_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       bcast_mode;

  logic                       beat;
  logic                       lane_end;
  logic                       grp_end;
  logic                       last_beat;
  logic                       cmd_legal;
  logic [FILTERNUM_WIDTH:0]   cmd_span;
  logic [FILTERNUM_WIDTH:0]   ff_ext;
  logic [FILTERNUM_WIDTH:0]   grp_hi;
  logic [FILTERNUM_WIDTH:0]   end_grp;
  logic [MAX_KERNELNUM-1:0]   lane_onehot;

`ifdef PE_LOAD_BCAST_EN
  logic bcast_q, bcast_d;
  assign bcast_mode = bcast_q;
`else
  assign bcast_mode = 1'b0;
`endif

  // Command check, beat qualification and write-enable decode
  always_comb begin
    cmd_span  = {1'b0, first_filter} + {1'b0, num_filter};
    cmd_legal = (num_filter != '0) && (num_kernel != '0) &&
                (num_kernel <= MaxKernel) && (cmd_span <= GroupsExt);

    ff_ext    = {1'b0, ff_q};
    grp_hi    = ff_ext + {1'b0, nf_q};
    end_grp   = grp_hi - FwExt'(1);

    beat      = (state_q == StLoad) && w_valid;
    lane_end  = (lane_q == nk_q - KERNELNUM_WIDTH'(1));
    grp_end   = ({1'b0, grp_q} == end_grp);
    // In broadcast mode every selected group is written per beat, so the lane alone ends it
    last_beat = beat && lane_end && (bcast_mode || grp_end);

    lane_onehot = MAX_KERNELNUM'(1) << lane_q;
    pe_en       = '0;
    if (beat) begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        if (bcast_mode ? ((FwExt'(g) >= ff_ext) && (FwExt'(g) < grp_hi))
                       : (grp_q == FILTERNUM_WIDTH'(g))) begin
          pe_en[g*MAX_KERNELNUM +: MAX_KERNELNUM] = lane_onehot;
        end
      end
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    w_ready    = (state_q == StLoad);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    cfg_err    = cfg_err_q;
    cur_filter = grp_q;
    cur_kernel = lane_q;
    last       = last_beat;
  end

  // Next-state: command acceptance, lane/group walk, completion
  always_comb begin
    state_d   = state_q;
    nf_d      = nf_q;
    nk_d      = nk_q;
    ff_d      = ff_q;
    grp_d     = grp_q;
    lane_d    = lane_q;
    cfg_err_d = 1'b0;
`ifdef PE_LOAD_BCAST_EN
    bcast_d   = bcast_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cmd_legal) begin
            state_d = StLoad;
            nf_d    = num_filter;
            nk_d    = num_kernel;
            ff_d    = first_filter;
            grp_d   = first_filter;
            lane_d  = '0;
`ifdef PE_LOAD_BCAST_EN
            bcast_d = bcast;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (beat) begin
          // Final beat leaves the counters on the last written PE
          if (last_beat) begin
            state_d = StDone;
          end else if (lane_end) begin
            lane_d = '0;
            grp_d  = grp_q + FILTERNUM_WIDTH'(1);
          end else begin
            lane_d = lane_q + KERNELNUM_WIDTH'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      nf_q      <= '0;
      nk_q      <= '0;
      ff_q      <= '0;
      grp_q     <= '0;
      lane_q    <= '0;
      cfg_err_q <= 1'b0;
`ifdef PE_LOAD_BCAST_EN
      bcast_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      nf_q      <= nf_d;
      nk_q      <= nk_d;
      ff_q      <= ff_d;
      grp_q     <= grp_d;
      lane_q    <= lane_d;
      cfg_err_q <= cfg_err_d;
`ifdef PE_LOAD_BCAST_EN
      bcast_q   <= bcast_d;
`endif
    end
  end

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Testbench for pe_load_sequencer. A queue-based model of the expected beats is
// checked against the DUT on every negedge. Literal beat lists pin the model.
module tb_pe_load_sequencer;

  localparam int FW = 7;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] num_filter = '0;
  logic [KW-1:0] num_kernel = '0;
  logic [FW-1:0] first_filter = '0;
  logic          w_valid = 1'b0;
  logic          bcast_in = 1'b0;
  logic          w_ready;
  logic [63:0]   pe_en;
  logic [FW-1:0] cur_filter;
  logic [KW-1:0] cur_kernel;
  logic          last;
  logic          busy;
  logic          done;
  logic          cfg_err;

  pe_load_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef PE_LOAD_BCAST_EN
    .bcast        (bcast_in),
`endif
    .start        (start),
    .num_filter   (num_filter),
    .num_kernel   (num_kernel),
    .first_filter (first_filter),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .pe_en        (pe_en),
    .cur_filter   (cur_filter),
    .cur_kernel   (cur_kernel),
    .last         (last),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [63:0] mask;
    int          f;
    int          k;
    bit          lst;
  } beat_t;

  beat_t       mq[$];
  int          m_phase = 0;   // 0 idle, 1 loading, 2 done
  int          m_cf = 0;
  int          m_ck = 0;
  bit          m_err = 1'b0;
  logic [63:0] cap_mask[$];
  bit          cap_last[$];
  int          n_done = 0;
  int          n_err = 0;

  // Compare DUT against the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    beat_t h;
    beat_t b;
    int    nf, nk, ff;
    bit    err_n;
    h = '{mask: '0, f: 0, k: 0, lst: 1'b0};
    if (m_phase == 1) h = mq[0];
    chk("busy",    busy,    m_phase != 0);
    chk("w_ready", w_ready, m_phase == 1);
    chk("done",    done,    m_phase == 2);
    chk("cfg_err", cfg_err, m_err);
    if (m_phase == 1) begin
      chk("pe_en",      pe_en,      w_valid ? h.mask : 64'd0);
      chk("last",       last,       w_valid && h.lst);
      chk("cur_filter", cur_filter, h.f);
      chk("cur_kernel", cur_kernel, h.k);
    end else begin
      chk("pe_en_idle",      pe_en,      64'd0);
      chk("last_idle",       last,       1'b0);
      chk("cur_filter_hold", cur_filter, m_cf);
      chk("cur_kernel_hold", cur_kernel, m_ck);
    end
    if (w_ready === 1'b1 && w_valid) begin
      cap_mask.push_back(pe_en);
      cap_last.push_back(last);
    end
    if (done === 1'b1) n_done++;
    if (cfg_err === 1'b1) n_err++;

    if (!reset_n) begin
      m_phase = 0;
      mq.delete();
      m_cf  = 0;
      m_ck  = 0;
      m_err = 1'b0;
    end else begin
      err_n = 1'b0;
      case (m_phase)
        0: if (start) begin
          nf = int'(num_filter);
          nk = int'(num_kernel);
          ff = int'(first_filter);
          if (nf != 0 && nk != 0 && nk <= 8 && ff + nf <= 8) begin
            mq.delete();
            if (bcast_in) begin
              for (int k = 0; k < nk; k++) begin
                b.mask = '0;
                for (int g = ff; g < ff + nf; g++) b.mask[g*8+k] = 1'b1;
                b.f = ff;
                b.k = k;
                b.lst = (k == nk - 1);
                mq.push_back(b);
              end
            end else begin
              for (int g = ff; g < ff + nf; g++) begin
                for (int k = 0; k < nk; k++) begin
                  b.mask = 64'd1 << (g * 8 + k);
                  b.f = g;
                  b.k = k;
                  b.lst = (g == ff + nf - 1) && (k == nk - 1);
                  mq.push_back(b);
                end
              end
            end
            m_phase = 1;
          end else begin
            err_n = 1'b1;
          end
        end
        1: if (w_valid) begin
          h = mq.pop_front();
          m_cf = h.f;
          m_ck = h.k;
          if (h.lst) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
      m_err = err_n;
    end
  end

  task automatic drive_cmd(input int nf, input int nk, input int ff, input bit bc,
                           input bit stall);
    bit ok = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    num_filter = FW'(nf);
    num_kernel = KW'(nk);
    first_filter = FW'(ff);
    bcast_in = bc;
    w_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (m_phase == 0) begin
        ok = 1'b1;
        break;
      end
      w_valid = stall ? (i % 3 == 0) : 1'b1;
    end
    w_valid = 1'b0;
    chk("cmd_complete", ok, 1'b1);
  endtask

  int e1[6] = '{0, 1, 2, 8, 9, 10};
  int e2[8] = '{56, 57, 58, 59, 60, 61, 62, 63};
  int e4[6] = '{0, 1, 8, 9, 16, 17};
  int e5[3] = '{0, 1, 2};

  initial begin
    int base, dbase, ebase;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Test 1: nf=2 nk=3 ff=0, continuous valid
    base = cap_mask.size(); dbase = n_done;
    drive_cmd(2, 3, 0, 1'b0, 1'b0);
    chk("t1_count", cap_mask.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < cap_mask.size()) chk($sformatf("t1_beat%0d", i), cap_mask[base+i], 64'd1 << e1[i]);
    if (base + 5 < cap_last.size()) chk("t1_last6", cap_last[base+5], 1'b1);
    chk("t1_done", n_done - dbase, 1);
    chk("t1_ready_after", w_ready, 1'b0);

    // Test 2: last group fully populated
    base = cap_mask.size(); ebase = n_err;
    drive_cmd(1, 8, 7, 1'b0, 1'b0);
    chk("t2_count", cap_mask.size() - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < cap_mask.size()) chk($sformatf("t2_beat%0d", i), cap_mask[base+i], 64'd1 << e2[i]);
    chk("t2_no_err", n_err - ebase, 0);

    // Test 3: illegal commands
    base = cap_mask.size(); ebase = n_err; dbase = n_done;
    drive_cmd(0, 3, 0, 1'b0, 1'b0);
    drive_cmd(1, 9, 0, 1'b0, 1'b0);
    drive_cmd(3, 2, 6, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    chk("t3_err_count", n_err - ebase, 3);
    chk("t3_no_beats", cap_mask.size() - base, 0);
    chk("t3_no_done", n_done - dbase, 0);

    // Test 4: stalls with valid pattern 1,0,0
    base = cap_mask.size();
    drive_cmd(3, 2, 0, 1'b0, 1'b1);
    chk("t4_count", cap_mask.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < cap_mask.size()) chk($sformatf("t4_beat%0d", i), cap_mask[base+i], 64'd1 << e4[i]);

    // Test 5: reset after the 3rd beat, then a fresh command
    base = cap_mask.size(); dbase = n_done;
    @(posedge clk); #1;
    start = 1'b1; num_filter = 7'd2; num_kernel = 4'd3; first_filter = 7'd0; bcast_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; w_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 w_valid = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    chk("t5_busy_cleared", busy, 1'b0);
    chk("t5_count", cap_mask.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (base + i < cap_mask.size()) chk($sformatf("t5_beat%0d", i), cap_mask[base+i], 64'd1 << e5[i]);
    chk("t5_no_done", n_done - dbase, 0);
    base = cap_mask.size();
    drive_cmd(1, 2, 0, 1'b0, 1'b0);
    chk("t5b_count", cap_mask.size() - base, 2);
    if (base + 1 < cap_mask.size()) begin
      chk("t5b_beat0", cap_mask[base], 64'h1);
      chk("t5b_beat1", cap_mask[base+1], 64'h2);
    end

`ifdef PE_LOAD_BCAST_EN
    // Test 6: broadcast across four groups
    base = cap_mask.size(); dbase = n_done;
    drive_cmd(4, 2, 0, 1'b1, 1'b0);
    chk("t6_count", cap_mask.size() - base, 2);
    if (base + 1 < cap_mask.size()) begin
      chk("t6_beat0", cap_mask[base], 64'h0000_0000_0101_0101);
      chk("t6_beat1", cap_mask[base+1], 64'h0000_0000_0202_0202);
      chk("t6_last", cap_last[base+1], 1'b1);
    end
    chk("t6_done", n_done - dbase, 1);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
